// File: rtl/ldpc_ber_sweep.sv
// LDPC bit/frame error-rate sweep harness: fills frames from parallel noise
// channels, runs the decoder core and reports error counts per SNR point.
module ldpc_ber_sweep #(
  parameter int DATA_W  = 5,
  parameter int R       = 24,
  parameter int D       = 96,
  parameter int CH      = 128,
  parameter int POP_W   = 64,
  parameter int SNR_W   = 4,
  parameter int FCNT_W  = 16,
  parameter int BCNT_W  = 32,
  parameter int TIMEOUT = 4095,
  localparam int DIM    = R * D,
  localparam int SEG    = DIM / CH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SNR_W-1:0]         snr_first,
  input  logic [SNR_W-1:0]         snr_last,
  input  logic [FCNT_W-1:0]        frames_max,
  input  logic [FCNT_W-1:0]        ferr_max,
  input  logic [CH-1:0]            llr_valid,
  input  logic [CH*DATA_W-1:0]     llr_in,
  output logic [CH-1:0]            llr_ce,
  output logic [SNR_W-1:0]         snr_idx,
  output logic [DIM*DATA_W-1:0]    dec_llr,
  output logic                     dec_rst,
  output logic                     dec_en,
  input  logic [DIM-1:0]           dec_res,
  input  logic                     dec_term,
  input  logic                     dec_err,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SNR_W-1:0]         res_snr,
  output logic [FCNT_W-1:0]        res_frames,
  output logic [FCNT_W-1:0]        res_ferr,
  output logic [BCNT_W-1:0]        res_berr,
  output logic [FCNT_W-1:0]        res_tout,
  output logic                     busy,
  output logic                     done
);

  localparam int BW   = SEG * DATA_W;
  localparam int CW   = $clog2(SEG + 1);
  localparam int NPOP = DIM / POP_W;
  localparam int AW   = (NPOP > 1) ? $clog2(NPOP) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int PCW  = $clog2(POP_W + 1);
  localparam int BW1  = BCNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_DECODE,
    S_ACCUM,
    S_REPORT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [BW-1:0]          r_buf [CH];
  logic [CW-1:0]          r_cnt [CH];
  logic [SNR_W-1:0]       r_first;
  logic [SNR_W-1:0]       r_last;
  logic [FCNT_W-1:0]      r_fmax;
  logic [FCNT_W-1:0]      r_emax;
  logic [SNR_W-1:0]       r_snr;
  logic [FCNT_W-1:0]      r_frames;
  logic [FCNT_W-1:0]      r_ferr;
  logic [FCNT_W-1:0]      r_tout;
  logic [BCNT_W-1:0]      r_berr;
  logic [TW-1:0]          r_cyc;
  logic [AW-1:0]          r_acc;
  logic [DIM-1:0]         r_res;
  logic [DIM*DATA_W-1:0]  r_dec_llr;
  logic                   r_res_valid;
  logic [SNR_W-1:0]       r_res_snr;
  logic [FCNT_W-1:0]      r_res_frames;
  logic [FCNT_W-1:0]      r_res_ferr;
  logic [BCNT_W-1:0]      r_res_berr;
  logic [FCNT_W-1:0]      r_res_tout;

  logic [CH-1:0]          w_full;
  logic                   w_ready;
  logic                   w_active;
  logic [DIM*DATA_W-1:0]  w_frame;
  logic                   w_go;
  logic                   w_term_hit;
  logic                   w_tout_hit;
  logic                   w_hs;
  logic                   w_last_pt;
  logic                   w_flush;
  logic [FCNT_W-1:0]      w_frames_inc;
  logic [FCNT_W-1:0]      w_ferr_inc;
  logic [FCNT_W-1:0]      w_tout_inc;
  logic [PCW-1:0]         w_pop;
  logic [BW1-1:0]         w_sum;

  function automatic logic [FCNT_W-1:0] f_inc(input logic [FCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PCW-1:0] f_pop(input logic [POP_W-1:0] v);
    logic [PCW-1:0] s;
    s = '0;
    for (int k = 0; k < POP_W; k++) s = s + PCW'(v[k]);
    return s;
  endfunction

  function automatic logic f_end(
    input logic [FCNT_W-1:0] fr,
    input logic [FCNT_W-1:0] fe,
    input logic [FCNT_W-1:0] fm,
    input logic [FCNT_W-1:0] em
  );
    return (fr == fm) || ((em != '0) && (fe >= em));
  endfunction

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign w_full[i] = (r_cnt[i] == CW'(SEG));
    assign w_frame[i*BW +: BW] = r_buf[i];
  end

  assign w_ready      = &w_full;
  assign w_active     = (r_state == S_FILL) || (r_state == S_LOAD) ||
                        (r_state == S_DECODE) || (r_state == S_ACCUM) ||
                        (r_state == S_REPORT);
  assign w_frames_inc = f_inc(r_frames);
  assign w_ferr_inc   = f_inc(r_ferr);
  assign w_tout_inc   = f_inc(r_tout);
  assign w_last_pt    = (r_snr == r_last) || (r_first > r_last);
  assign w_pop        = f_pop(r_res[r_acc*POP_W +: POP_W]);
  assign w_sum        = {1'b0, r_berr} + BW1'(w_pop);
  assign w_flush      = w_go || (r_state == S_LOAD) ||
                        (w_hs && !w_last_pt);

  always_comb begin
    w_next     = r_state;
    w_go       = 1'b0;
    w_term_hit = 1'b0;
    w_tout_hit = 1'b0;
    w_hs       = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_go   = 1'b1;
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        if (w_ready) w_next = S_LOAD;
      end
      S_LOAD: w_next = S_DECODE;
      S_DECODE: begin
        if (dec_term) begin
          w_term_hit = 1'b1;
          w_next     = S_ACCUM;
        end else if (r_cyc == TW'(TIMEOUT - 1)) begin
          w_tout_hit = 1'b1;
          if (f_end(w_frames_inc, w_ferr_inc, r_fmax, r_emax))
            w_next = S_REPORT;
          else
            w_next = w_ready ? S_LOAD : S_FILL;
        end
      end
      S_ACCUM: begin
        if (r_acc == AW'(NPOP - 1)) begin
          if (f_end(r_frames, r_ferr, r_fmax, r_emax))
            w_next = S_REPORT;
          else
            w_next = w_ready ? S_LOAD : S_FILL;
        end
      end
      S_REPORT: begin
        if (r_res_valid && res_ready) begin
          w_hs   = 1'b1;
          w_next = w_last_pt ? S_DONE : S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Fill buffers keep running while the previous frame decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        r_buf[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (w_flush) begin
      for (int i = 0; i < CH; i++) begin
        r_buf[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (w_active) begin
      for (int i = 0; i < CH; i++) begin
        if (llr_valid[i] && !w_full[i]) begin
          r_buf[i] <= (r_buf[i] << DATA_W) |
                      BW'(llr_in[i*DATA_W +: DATA_W]);
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first      <= '0;
      r_last       <= '0;
      r_fmax       <= '0;
      r_emax       <= '0;
      r_snr        <= '0;
      r_frames     <= '0;
      r_ferr       <= '0;
      r_tout       <= '0;
      r_berr       <= '0;
      r_cyc        <= '0;
      r_acc        <= '0;
      r_res        <= '0;
      r_dec_llr    <= '0;
      r_res_valid  <= 1'b0;
      r_res_snr    <= '0;
      r_res_frames <= '0;
      r_res_ferr   <= '0;
      r_res_berr   <= '0;
      r_res_tout   <= '0;
    end else begin
      if (w_go) begin
        r_first  <= snr_first;
        r_last   <= snr_last;
        r_fmax   <= (frames_max == '0) ? FCNT_W'(1) : frames_max;
        r_emax   <= ferr_max;
        r_snr    <= snr_first;
        r_frames <= '0;
        r_ferr   <= '0;
        r_tout   <= '0;
        r_berr   <= '0;
      end
      if (r_state == S_LOAD) begin
        r_dec_llr <= w_frame;
        r_cyc     <= '0;
      end
      if (r_state == S_DECODE && !w_term_hit && !w_tout_hit)
        r_cyc <= r_cyc + 1'b1;
      if (w_term_hit) begin
        r_res    <= dec_res;
        r_frames <= w_frames_inc;
        r_ferr   <= dec_err ? w_ferr_inc : r_ferr;
        r_acc    <= '0;
      end
      // Aborted frames count as errored but contribute no bit errors.
      if (w_tout_hit) begin
        r_frames <= w_frames_inc;
        r_ferr   <= w_ferr_inc;
        r_tout   <= w_tout_inc;
      end
      if (r_state == S_ACCUM) begin
        r_berr <= w_sum[BCNT_W] ? '1 : w_sum[BCNT_W-1:0];
        r_acc  <= r_acc + 1'b1;
      end
      if (r_state == S_REPORT && !r_res_valid) begin
        r_res_valid  <= 1'b1;
        r_res_snr    <= r_snr;
        r_res_frames <= r_frames;
        r_res_ferr   <= r_ferr;
        r_res_berr   <= r_berr;
        r_res_tout   <= r_tout;
      end
      if (w_hs) begin
        r_res_valid <= 1'b0;
        if (!w_last_pt) begin
          r_snr    <= r_snr + 1'b1;
          r_frames <= '0;
          r_ferr   <= '0;
          r_tout   <= '0;
          r_berr   <= '0;
        end
      end
    end
  end

  assign llr_ce     = w_active ? ~w_full : '0;
  assign snr_idx    = r_snr;
  assign dec_llr    = r_dec_llr;
  assign dec_rst    = (r_state == S_LOAD);
  assign dec_en     = (r_state == S_LOAD) || (r_state == S_DECODE);
  assign res_valid  = r_res_valid;
  assign res_snr    = r_res_snr;
  assign res_frames = r_res_frames;
  assign res_ferr   = r_res_ferr;
  assign res_berr   = r_res_berr;
  assign res_tout   = r_res_tout;
  assign busy       = w_active;
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_ldpc_ber_sweep.sv
// Directed bench for ldpc_ber_sweep with a small behavioural decoder model.
module tb_ldpc_ber_sweep;
  localparam int DATA_W  = 5;
  localparam int R       = 4;
  localparam int D       = 4;
  localparam int CH      = 4;
  localparam int POP_W   = 8;
  localparam int SNR_W   = 4;
  localparam int FCNT_W  = 16;
  localparam int BCNT_W  = 32;
  localparam int TIMEOUT = 20;
  localparam int DIM     = R * D;
  localparam int SEG     = DIM / CH;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [SNR_W-1:0]      snr_first;
  logic [SNR_W-1:0]      snr_last;
  logic [FCNT_W-1:0]     frames_max;
  logic [FCNT_W-1:0]     ferr_max;
  logic [CH-1:0]         llr_valid;
  logic [CH*DATA_W-1:0]  llr_in;
  logic [CH-1:0]         llr_ce;
  logic [SNR_W-1:0]      snr_idx;
  logic [DIM*DATA_W-1:0] dec_llr;
  logic                  dec_rst;
  logic                  dec_en;
  logic [DIM-1:0]        dec_res;
  logic                  dec_term;
  logic                  dec_err;
  logic                  res_valid;
  logic                  res_ready;
  logic [SNR_W-1:0]      res_snr;
  logic [FCNT_W-1:0]     res_frames;
  logic [FCNT_W-1:0]     res_ferr;
  logic [BCNT_W-1:0]     res_berr;
  logic [FCNT_W-1:0]     res_tout;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int failures = 0;
  int c = 0;
  bit ch2_slow = 0;
  logic [DIM-1:0] m_res = '0;
  bit m_err = 0;
  bit m_term_en = 1;
  int m_cnt = 0;

  ldpc_ber_sweep #(
    .DATA_W(DATA_W), .R(R), .D(D), .CH(CH), .POP_W(POP_W),
    .SNR_W(SNR_W), .FCNT_W(FCNT_W), .BCNT_W(BCNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .snr_first(snr_first), .snr_last(snr_last),
    .frames_max(frames_max), .ferr_max(ferr_max),
    .llr_valid(llr_valid), .llr_in(llr_in), .llr_ce(llr_ce),
    .snr_idx(snr_idx), .dec_llr(dec_llr),
    .dec_rst(dec_rst), .dec_en(dec_en),
    .dec_res(dec_res), .dec_term(dec_term), .dec_err(dec_err),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_snr(res_snr), .res_frames(res_frames), .res_ferr(res_ferr),
    .res_berr(res_berr), .res_tout(res_tout),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder model: dec_term high in the 5th cycle after the load strobe.
  always @(posedge clk) begin
    if (dec_rst) m_cnt <= 1;
    else if (m_cnt != 0 && m_cnt < 7) m_cnt <= m_cnt + 1;
  end
  assign dec_term = m_term_en && (m_cnt == 5);
  assign dec_res  = m_res;
  assign dec_err  = m_err;

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      llr_in[i*DATA_W +: DATA_W] = DATA_W'(c + 8 * i);
      llr_valid[i] = (i == 2 && ch2_slow) ? (c % 3 == 0) : 1'b1;
    end
    c++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic do_start(input int f, input int l, input int fm,
                          input int em);
    snr_first  = SNR_W'(f);
    snr_last   = SNR_W'(l);
    frames_max = FCNT_W'(fm);
    ferr_max   = FCNT_W'(em);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int k = 0; k < 600; k++) begin
      if (res_valid) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy, done, res_valid, dec_en, dec_rst} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {busy, done, res_valid, dec_en, dec_rst});
    end
    checks++;
    if (llr_ce !== 4'b0 || snr_idx !== 4'd0 || dec_llr !== '0) begin
      failures++;
      $display("FAIL reset_data ce=%b snr=%0d llr=%0h exp=0",
               llr_ce, snr_idx, dec_llr);
    end
  endtask

  task automatic test_sweep();
    bit ok;
    apply_reset();
    m_res = '0; m_err = 0; m_term_en = 1; ch2_slow = 0;
    do_start(2, 4, 3, 0);
    for (int p = 0; p < 3; p++) begin
      wait_valid(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL sweep_valid%0d got=timeout exp=res_valid", p);
      end
      checks++;
      if (res_snr !== SNR_W'(2 + p) || snr_idx !== SNR_W'(2 + p)) begin
        failures++;
        $display("FAIL sweep_snr%0d got=%0d/%0d exp=%0d",
                 p, res_snr, snr_idx, 2 + p);
      end
      checks++;
      if (res_frames !== 16'd3 || res_ferr !== 16'd0 ||
          res_berr !== 32'd0 || res_tout !== 16'd0) begin
        failures++;
        $display("FAIL sweep_cnt%0d got=%0d/%0d/%0d/%0d exp=3/0/0/0", p,
                 res_frames, res_ferr, res_berr, res_tout);
      end
      handshake();
      checks++;
      if (p < 2) begin
        if (snr_idx !== SNR_W'(3 + p) || res_valid !== 1'b0 ||
            busy !== 1'b1) begin
          failures++;
          $display("FAIL sweep_step%0d got=%0d/%b/%b exp=%0d/0/1", p,
                   snr_idx, res_valid, busy, 3 + p);
        end
      end else begin
        if (done !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL sweep_done got=%b/%b exp=1/0", done, busy);
        end
      end
    end
  endtask

  task automatic test_berr();
    bit ok;
    int k;
    apply_reset();
    m_res = 16'h00F3; m_err = 1; m_term_en = 1; ch2_slow = 0;
    do_start(5, 5, 2, 0);
    k = 0;
    while (!dec_rst && k < 100) begin step(); k++; end
    k = 0;
    while (!dec_term && k < 100) begin step(); k++; end
    k = 0;
    while (!dec_rst && k < 100) begin step(); k++; end
    checks++;
    if (k !== 3) begin
      failures++;
      $display("FAIL accum_len got=%0d exp=3 (2 accum + load)", k);
    end
    wait_valid(ok);
    checks++;
    if (!ok || res_berr !== 32'd12 || res_ferr !== 16'd2 ||
        res_frames !== 16'd2 || res_tout !== 16'd0) begin
      failures++;
      $display("FAIL berr got=%0d/%0d/%0d/%0d exp=12/2/2/0",
               res_berr, res_ferr, res_frames, res_tout);
    end
    handshake();
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    int n;
    apply_reset();
    m_res = 16'h00F3; m_err = 0; m_term_en = 0; ch2_slow = 0;
    do_start(1, 1, 2, 0);
    k = 0;
    while (!dec_rst && k < 100) begin step(); k++; end
    step();
    n = 0;
    while (dec_en && !dec_rst && n < 100) begin step(); n++; end
    checks++;
    if (n !== TIMEOUT) begin
      failures++;
      $display("FAIL tout_len got=%0d exp=%0d", n, TIMEOUT);
    end
    wait_valid(ok);
    checks++;
    if (!ok || res_frames !== 16'd2 || res_ferr !== 16'd2 ||
        res_tout !== 16'd2 || res_berr !== 32'd0) begin
      failures++;
      $display("FAIL tout got=%0d/%0d/%0d/%0d exp=2/2/2/0",
               res_frames, res_ferr, res_tout, res_berr);
    end
    handshake();
    m_term_en = 1;
  endtask

  task automatic test_early_stop();
    bit ok;
    apply_reset();
    m_res = '0; m_err = 1; m_term_en = 1; ch2_slow = 0;
    do_start(7, 3, 100, 1);
    wait_valid(ok);
    checks++;
    if (!ok || res_frames !== 16'd1 || res_ferr !== 16'd1 ||
        res_snr !== 4'd7) begin
      failures++;
      $display("FAIL early got=%0d/%0d/%0d exp=1/1/7",
               res_frames, res_ferr, res_snr);
    end
    handshake();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL early_done got=%b/%b exp=1/0", done, busy);
    end
  endtask

  task automatic test_fill_layout();
    logic [DIM*DATA_W-1:0] exp_llr;
    int cv;
    apply_reset();
    m_res = '0; m_err = 0; m_term_en = 1; ch2_slow = 1;
    c = 0;
    do_start(0, 0, 1, 0);
    repeat (9) step();
    checks++;
    if (llr_ce !== 4'b0100) begin
      failures++;
      $display("FAIL ce_pre got=%b exp=0100", llr_ce);
    end
    step();
    checks++;
    if (llr_ce !== 4'b0000 || dec_rst !== 1'b0) begin
      failures++;
      $display("FAIL ce_full got=%b/%b exp=0000/0", llr_ce, dec_rst);
    end
    step();
    checks++;
    if (dec_rst !== 1'b1) begin
      failures++;
      $display("FAIL load_time got=%b exp=1", dec_rst);
    end
    step();
    exp_llr = '0;
    for (int i = 0; i < CH; i++)
      for (int k = 0; k < SEG; k++) begin
        cv = (i == 2) ? 3 * k : k;
        exp_llr[i*SEG*DATA_W + (SEG-1-k)*DATA_W +: DATA_W] =
          DATA_W'(cv + 8 * i);
      end
    checks++;
    if (dec_llr !== exp_llr) begin
      failures++;
      $display("FAIL layout got=%h exp=%h", dec_llr, exp_llr);
    end
    ch2_slow = 0;
  endtask

  task automatic test_hold_and_abort();
    bit ok;
    int k;
    apply_reset();
    m_res = '0; m_err = 0; m_term_en = 1; ch2_slow = 0;
    do_start(1, 1, 1, 0);
    wait_valid(ok);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (!(ok && res_valid === 1'b1 && res_snr === 4'd1 &&
            res_frames === 16'd1 && res_ferr === 16'd0 &&
            dec_rst === 1'b0)) begin
        failures++;
        $display("FAIL hold%0d got=%b/%0d/%0d/%b exp=1/1/1/0", j,
                 res_valid, res_snr, res_frames, dec_rst);
      end
      step();
    end
    handshake();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL hold_done got=%b exp=1", done);
    end
    do_start(3, 6, 5, 0);
    k = 0;
    while (!dec_rst && k < 100) begin step(); k++; end
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, res_valid, dec_en, dec_rst} !== 5'b0 ||
        llr_ce !== 4'b0 || snr_idx !== 4'd0 || dec_llr !== '0 ||
        res_frames !== 16'd0) begin
      failures++;
      $display("FAIL abort got=%b ce=%b snr=%0d",
               {busy, done, res_valid, dec_en, dec_rst}, llr_ce, snr_idx);
    end
    step();
    checks++;
    if (busy !== 1'b0 || dec_en !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got=%b/%b/%b exp=0/0/0",
               busy, dec_en, res_valid);
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    res_ready = 1'b0;
    snr_first = '0;
    snr_last = '0;
    frames_max = '0;
    ferr_max = '0;
    llr_valid = '0;
    llr_in = '0;
    test_reset();
    test_sweep();
    test_berr();
    test_timeout();
    test_early_stop();
    test_fill_layout();
    test_hold_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
